// File: rtl/xbar_periph_responder.sv
// Word-addressed peripheral responder: byte-enable writes, reads, out-of-range error, fixed wait states.
// Ready comes WAIT_CYCLES after the accept cycle (same cycle when 0); initiator holds p_req_i until ready.
module xbar_periph_responder #(
  parameter int unsigned WORD_ADDR_WIDTH = 8,
  parameter int unsigned NUM_WORDS       = 16,
  parameter int unsigned WAIT_CYCLES     = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       p_req_i,
  input  logic [WORD_ADDR_WIDTH-1:0] p_addr_i,
  input  logic                       p_we_i,
  input  logic [3:0]                 p_be_i,
  input  logic [31:0]                p_wdata_i,
  output logic                       p_ready_o,
  output logic [31:0]                p_rdata_o,
  output logic                       p_err_o
);

  localparam int unsigned              IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WORD_ADDR_WIDTH:0] WORDS_L  = (WORD_ADDR_WIDTH + 1)'(NUM_WORDS);
  localparam logic [3:0]               CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit                       NO_WAIT  = (WAIT_CYCLES == 0);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

  state_e                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [WORD_ADDR_WIDTH-1:0] cap_addr_q;
  logic                       cap_we_q;
  logic [3:0]                 cap_be_q;
  logic [31:0]                cap_wdata_q;
  logic [31:0]                mem_q [NUM_WORDS];

  logic                       capture;
  logic                       fire;
  logic [WORD_ADDR_WIDTH-1:0] act_addr;
  logic                       act_we;
  logic [3:0]                 act_be;
  logic [31:0]                act_wdata;
  logic                       in_range;
  logic [IDX_W-1:0]           idx;
  logic                       wr_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (p_req_i) begin
          if (NO_WAIT) begin
            fire = 1'b1;
          end else begin
            capture = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // bus inputs are ignored here; the captured request always completes
        if (cnt_q == 4'd0) begin
          fire    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign act_addr  = NO_WAIT ? p_addr_i  : cap_addr_q;
  assign act_we    = NO_WAIT ? p_we_i    : cap_we_q;
  assign act_be    = NO_WAIT ? p_be_i    : cap_be_q;
  assign act_wdata = NO_WAIT ? p_wdata_i : cap_wdata_q;

  assign in_range  = ({1'b0, act_addr} < WORDS_L);
  assign idx       = act_addr[IDX_W-1:0];

  // reset masks the outputs so the zero-wait path cannot respond while held in reset
  assign p_ready_o = rst_ni & fire;
  assign p_err_o   = p_ready_o & ~in_range;
  assign p_rdata_o = (p_ready_o & ~act_we & in_range) ? mem_q[idx] : 32'd0;
  assign wr_en     = p_ready_o & act_we & in_range;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      cap_addr_q  <= '0;
      cap_we_q    <= 1'b0;
      cap_be_q    <= 4'd0;
      cap_wdata_q <= 32'd0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        cap_addr_q  <= p_addr_i;
        cap_we_q    <= p_we_i;
        cap_be_q    <= p_be_i;
        cap_wdata_q <= p_wdata_i;
      end
      if (wr_en) begin
        for (int k = 0; k < 4; k++) begin
          if (act_be[k]) begin
            mem_q[idx][8*k +: 8] <= act_wdata[8*k +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_xbar_periph_responder.sv
// Bench for xbar_periph_responder: four instances with WAIT_CYCLES 0..3, a completion-time model checked every cycle,
// and directed transactions with literal expectations.
module tb_xbar_periph_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req   [4];
  logic [7:0]  addr  [4];
  logic        we    [4];
  logic [3:0]  be    [4];
  logic [31:0] wd    [4];
  logic        rdy   [4];
  logic [31:0] rd    [4];
  logic        err   [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    xbar_periph_responder #(
      .WORD_ADDR_WIDTH(8),
      .NUM_WORDS      (16),
      .WAIT_CYCLES    (g)
    ) u_dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .p_req_i  (req[g]),
      .p_addr_i (addr[g]),
      .p_we_i   (we[g]),
      .p_be_i   (be[g]),
      .p_wdata_i(wd[g]),
      .p_ready_o(rdy[g]),
      .p_rdata_o(rd[g]),
      .p_err_o  (err[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%h expected=%h", nm, inst, act, exp);
    end
  endtask

  // Model: instance i (WAIT_CYCLES=i) completes a request accepted in cycle c during cycle c+i.
  int          cyc = 0;
  bit          busy  [4];
  int          due   [4];
  logic        t_we  [4];
  logic [7:0]  t_addr[4];
  logic [3:0]  t_be  [4];
  logic [31:0] t_wd  [4];
  logic [31:0] mmem  [4][16];
  logic        fire, f_we, e_rdy, e_err;
  logic [7:0]  f_addr;
  logic [3:0]  f_be;
  logic [31:0] f_wd, e_rd;

  initial begin
    for (int i = 0; i < 4; i++) begin
      busy[i] = 1'b0;
      due[i]  = 0;
      for (int a = 0; a < 16; a++) mmem[i][a] = 32'd0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      fire = 1'b0; e_rdy = 1'b0; e_err = 1'b0; e_rd = 32'd0;
      f_we = 1'b0; f_addr = 8'd0; f_be = 4'd0; f_wd = 32'd0;
      if (!rst_n) begin
        busy[i] = 1'b0;
        for (int a = 0; a < 16; a++) mmem[i][a] = 32'd0;
      end else if (!busy[i]) begin
        if (req[i]) begin
          if (i == 0) begin
            fire = 1'b1; f_we = we[i]; f_addr = addr[i]; f_be = be[i]; f_wd = wd[i];
          end else begin
            busy[i] = 1'b1; due[i] = cyc + i;
            t_we[i] = we[i]; t_addr[i] = addr[i]; t_be[i] = be[i]; t_wd[i] = wd[i];
          end
        end
      end else if (cyc == due[i]) begin
        busy[i] = 1'b0;
        fire = 1'b1; f_we = t_we[i]; f_addr = t_addr[i]; f_be = t_be[i]; f_wd = t_wd[i];
      end
      if (fire) begin
        e_rdy = 1'b1;
        if (f_addr >= 8'd16) begin
          e_err = 1'b1;
        end else if (f_we) begin
          for (int k = 0; k < 4; k++)
            if (f_be[k]) mmem[i][f_addr][8*k +: 8] = f_wd[8*k +: 8];
        end else begin
          e_rd = mmem[i][f_addr];
        end
      end
      chk("cyc_ready", i, {31'd0, rdy[i]}, {31'd0, e_rdy});
      chk("cyc_err",   i, {31'd0, err[i]}, {31'd0, e_err});
      chk("cyc_rdata", i, rd[i], e_rd);
    end
    cyc++;
  end

  task automatic txn(input int i, input logic w, input logic [7:0] a, input logic [3:0] b,
                     input logic [31:0] d, output int lat, output logic [31:0] r, output logic e);
    @(posedge clk); #1;
    req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wd[i] = d;
    lat = -1; r = 32'd0; e = 1'b0;
    for (int n = 0; n < 20 && lat < 0; n++) begin
      @(negedge clk);
      if (rdy[i]) begin
        lat = n; r = rd[i]; e = err[i];
      end
    end
  endtask

  task automatic idle(input int i);
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  int          lat, got, cnt;
  logic [31:0] r;
  logic        e;
  logic [5:0]  pat;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 8'd0; be[i] = 4'd0; wd[i] = 32'd0;
    end
    // zero-wait instance requested while in reset
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'd2;
    @(negedge clk);
    chk("rst_ready", 0, {31'd0, rdy[0]}, 32'd0);
    chk("rst_rdata", 0, rd[0], 32'd0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    rst_n  = 1'b1;

    // two wait states: write then read back
    txn(2, 1'b1, 8'd3, 4'hF, 32'hDEADBEEF, lat, r, e);
    chk("w2_lat", 2, lat, 32'd2);
    idle(2);
    txn(2, 1'b0, 8'd3, 4'h0, 32'd0, lat, r, e);
    chk("r2_lat", 2, lat, 32'd2);
    chk("r2_data", 2, r, 32'hDEADBEEF);
    chk("r2_err", 2, {31'd0, e}, 32'd0);
    idle(2);

    // zero wait states, back to back with partial byte enables
    txn(0, 1'b1, 8'd5, 4'hF, 32'h11223344, lat, r, e);
    chk("w0a_lat", 0, lat, 32'd0);
    txn(0, 1'b1, 8'd5, 4'b0101, 32'hAABBCCDD, lat, r, e);
    chk("w0b_lat", 0, lat, 32'd0);
    for (int n = 0; n < 3; n++) begin
      txn(0, 1'b0, 8'd5, 4'h0, 32'd0, lat, r, e);
      chk("r0_lat", 0, lat, 32'd0);
      chk("r0_data", 0, r, 32'h11BB33DD);
    end
    idle(0);

    // out-of-range address 16 aliases word 0 if the range guard is lost
    txn(1, 1'b1, 8'd16, 4'hF, 32'hFFFFFFFF, lat, r, e);
    chk("oor_w_err", 1, {31'd0, e}, 32'd1);
    idle(1);
    txn(1, 1'b0, 8'd16, 4'h0, 32'd0, lat, r, e);
    chk("oor_r_err", 1, {31'd0, e}, 32'd1);
    chk("oor_r_data", 1, r, 32'd0);
    idle(1);
    txn(1, 1'b0, 8'd0, 4'h0, 32'd0, lat, r, e);
    chk("oor_word0", 1, r, 32'd0);
    chk("oor_word0_err", 1, {31'd0, e}, 32'd0);
    idle(1);

    // three wait states: request dropped and address changed during the wait
    txn(3, 1'b1, 8'd2, 4'hF, 32'hCAFEF00D, lat, r, e);
    chk("w3_lat", 3, lat, 32'd3);
    idle(3);
    txn(3, 1'b1, 8'd7, 4'hF, 32'h07070707, lat, r, e);
    idle(3);
    @(posedge clk); #1;
    req[3] = 1'b1; we[3] = 1'b0; addr[3] = 8'd2;
    got = -1; r = 32'd0;
    @(negedge clk);
    if (rdy[3]) got = 0;
    @(posedge clk); #1;
    req[3] = 1'b0; addr[3] = 8'd7; we[3] = 1'b1; wd[3] = 32'd0;
    for (int n = 1; n < 6; n++) begin
      @(negedge clk);
      if (rdy[3] && got < 0) begin
        got = n; r = rd[3];
      end
    end
    chk("drop_lat", 3, got, 32'd3);
    chk("drop_data", 3, r, 32'hCAFEF00D);
    we[3] = 1'b0;

    // reset in the middle of a two-wait-state write
    @(posedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 8'd1; be[2] = 4'hF; wd[2] = 32'h55AA55AA;
    @(posedge clk); #1;
    rst_n = 1'b0;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'd5;
    @(negedge clk);
    chk("mid_rst_ready2", 2, {31'd0, rdy[2]}, 32'd0);
    chk("mid_rst_ready0", 0, {31'd0, rdy[0]}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; req[2] = 1'b0; req[0] = 1'b0;
    cnt = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (rdy[2]) cnt++;
    end
    chk("mid_rst_noready", 2, cnt, 32'd0);
    txn(2, 1'b0, 8'd1, 4'h0, 32'd0, lat, r, e);
    chk("mid_rst_lat", 2, lat, 32'd2);
    chk("mid_rst_data", 2, r, 32'd0);
    idle(2);

    // one wait state, request held high for six cycles
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'd0;
    pat = 6'd0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      pat = {pat[4:0], rdy[1]};
    end
    @(posedge clk); #1;
    req[1] = 1'b0;
    chk("b2b_pattern", 1, {26'd0, pat}, 32'h15);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
